pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage 16-bit pipeline. It drives the enable and flush controls of the IF/ID register, the PC write enable, the ID/EX bubble insert and the later-stage enables. It resolves four events: load-use hazards, taken-branch redirects, cache-miss stalls and HLT drain. It sits beside the decode stage and is the only source of stall/flush controls for the pipeline registers.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifid_instr  in  16  instruction currently held in IF/ID (the ID stage).
- idex_memrd  in  1  instruction in EX is a load.
- idex_rd  in  4  destination register of the EX instruction.
- branch_taken  in  1  a branch or BR resolved taken this cycle; redirect PC already muxed.
- icache_stall  in  1  fetch miss; the IF output is not valid.
- dcache_stall  in  1  data-memory miss in MEM.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads NOP (0x0000 treated as bubble) next edge.
- idex_bubble  out  1  ID/EX loads a bubble (control bits zeroed).
- back_en  out  1  EX/MEM and MEM/WB write enable.
- halted  out  1  processor halted, registered.
- stall_cnt  out  STALL_CNT_W  count of cycles with pc_en=0 since reset, saturating.

## Operation
- Decode from ifid_instr[15:12] (op):
  - rs = [7:4] is used for op 0000–1001 and 1101.
  - rt = [3:0] is used for op 0000–0011 and 0111.
  - The store (1001) also reads [11:8].
  - HLT = 1111.
- The load-use hazard (lu) is idex_memrd && idex_rd != 0 && idex_rd matches any used source field.
- States: RUN, DRAIN, HALTED.
- RUN, priority high to low:
  - dcache_stall: every enable is 0, flush=0, bubble=0. The whole pipe freezes.
  - branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, back_en=1.
  - lu: pc_en=0, ifid_en=0, idex_bubble=1, back_en=1.
  - icache_stall: pc_en=0, ifid_en=1, ifid_flush=1, back_en=1. This inserts a fetch bubble.
  - op==HLT: pc_en=0, ifid_en=1, ifid_flush=1, back_en=1. Load drain counter with 3 and go to DRAIN.
  - else: pc_en=ifid_en=back_en=1, flush=bubble=0.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_bubble=1, back_en=!dcache_stall.
  - The counter decrements only when back_en=1. At 0, go to HALTED.
  - branch_taken during DRAIN (the HLT was speculative) returns to RUN with the redirect outputs above.
- HALTED: all enables 0, halted=1. Only reset exits this state.
- stall_cnt increments every cycle pc_en=0 and stops at its maximum value.

## Timing
- Control outputs are combinational from state and the current inputs. halted and stall_cnt are registered.
- While rst=0:
  - State is RUN, counters are 0, halted=0, stall_cnt=0.
  - Outputs are forced pc_en=0, ifid_en=1, ifid_flush=1, idex_bubble=1, back_en=0.
- The first fetch is enabled in the first cycle after rst rises.
- A load-use stall lasts exactly 1 cycle. Next cycle the load has moved to MEM and lu drops.
- Branch penalty is 1 flushed IF/ID slot plus 1 ID/EX bubble.
- dcache_stall plus branch_taken in the same cycle: the freeze wins. branch_taken must be held by EX, which is frozen.
- rst asserted mid-DRAIN or in HALTED returns to RUN asynchronously.

## Structure
- Shared package holds:
  - opcode constants (OP_HLT, OP_SW, OP_B, OP_BR);
  - state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10);
  - a `uses_rs`/`uses_rt` decode function.
- One sub-module, `hazard_detect`: purely combinational lu computation. The FSM and counters stay in the top.

## Test plan
- Reset release with idle inputs: cycle 1 shows pc_en=1, ifid_en=1, flush=0, stall_cnt=0.
- LW into R3 in EX, ID = ADD R1,R3,R2 (0x0132): one cycle with pc_en=0, idex_bubble=1, stall_cnt=1. Next cycle is normal.
- Same as the previous case but idex_rd=0: no stall.
- branch_taken for 1 cycle: ifid_flush=1 and idex_bubble=1 for 1 cycle, pc_en=1.
- dcache_stall high for 5 cycles with branch_taken high: all enables 0 for 5 cycles, then the branch flush. stall_cnt=5.
- HLT (0xF000) in ID:
  - DRAIN lasts 3 cycles, stretched by 2 when a 2-cycle dcache_stall is injected.
  - Then halted=1 stays set.
  - rst low clears halted immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM state
// encoding, the control-output bundle and source-operand decode helpers.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] DRAIN_LOAD = 2'd3;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
    logic back_en;
  } ctl_t;

  localparam ctl_t CTL_RUN      = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0, back_en: 1'b1};
  localparam ctl_t CTL_FREEZE   = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0, back_en: 1'b0};
  localparam ctl_t CTL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1, back_en: 1'b1};
  localparam ctl_t CTL_LOADUSE  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1, back_en: 1'b1};
  localparam ctl_t CTL_FETCH_NOP = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0, back_en: 1'b1};
  localparam ctl_t CTL_RESET    = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1, back_en: 1'b0};

  function automatic logic uses_rs(input logic [3:0] op);
    return (op <= 4'd9) || (op == OP_BR);
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    return (op <= 4'd3) || (op == 4'd7);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stall/flush controls out.
//   slave  : the controller (reads status, drives controls)
//   master : the pipeline datapath (drives status, reads controls)
interface pipe_hazard_ctrl_if #(parameter int STALL_CNT_W = 16);
  logic [15:0]            ifid_instr;
  logic                   idex_memrd;
  logic [3:0]             idex_rd;
  logic                   branch_taken;
  logic                   icache_stall;
  logic                   dcache_stall;
  logic                   pc_en;
  logic                   ifid_en;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic                   back_en;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  ifid_instr, idex_memrd, idex_rd, branch_taken, icache_stall, dcache_stall,
    output pc_en, ifid_en, ifid_flush, idex_bubble, back_en, halted, stall_cnt
  );

  modport master (
    output ifid_instr, idex_memrd, idex_rd, branch_taken, icache_stall, dcache_stall,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, back_en, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection (combinational).
//   instr_i      : instruction in ID
//   idex_memrd_i : EX instruction is a load
//   idex_rd_i    : EX destination register
//   lu_o         : ID instruction reads the register the load is producing
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [15:0] instr_i,
  input  logic        idex_memrd_i,
  input  logic [3:0]  idex_rd_i,
  output logic        lu_o
);
  logic [3:0] op;
  logic       hit_rs, hit_rt, hit_sd;

  assign op     = instr_i[15:12];
  assign hit_rs = uses_rs(op) && (instr_i[7:4] == idex_rd_i);
  assign hit_rt = uses_rt(op) && (instr_i[3:0] == idex_rd_i);
  // Store reads its data register from the [11:8] field.
  assign hit_sd = (op == OP_SW) && (instr_i[11:8] == idex_rd_i);

  // R0 is hardwired, so a load into it never creates a dependency.
  assign lu_o = idex_memrd_i && (idex_rd_i != 4'd0) && (hit_rs || hit_rt || hit_sd);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
//   clk : pipeline clock
//   rst : asynchronous, active-low reset
//   bus : status inputs and stall/flush/enable controls (slave side)
// Controls are combinational from state and inputs; halted and stall_cnt
// are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);
  state_e                 state_q, state_d;
  logic [1:0]             drain_q, drain_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   halted_q;
  logic                   lu;
  logic                   dc;
  ctl_t                   ctl;

  assign dc = bus.dcache_stall;

  hazard_detect u_hazard_detect (
    .instr_i      (bus.ifid_instr),
    .idex_memrd_i (bus.idex_memrd),
    .idex_rd_i    (bus.idex_rd),
    .lu_o         (lu)
  );

  always_comb begin
    ctl     = CTL_FREEZE;
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        // A D-cache miss freezes EX too, so a pending branch waits there.
        if (dc)                   ctl = CTL_FREEZE;
        else if (bus.branch_taken) ctl = CTL_REDIRECT;
        else if (lu)              ctl = CTL_LOADUSE;
        else if (bus.icache_stall) ctl = CTL_FETCH_NOP;
        else if (bus.ifid_instr[15:12] == OP_HLT) begin
          ctl     = CTL_FETCH_NOP;
          drain_d = DRAIN_LOAD;
          state_d = DRAIN;
        end else                  ctl = CTL_RUN;
      end
      DRAIN: begin
        if (bus.branch_taken && !dc) begin
          // The HLT was on a mispredicted path.
          ctl     = CTL_REDIRECT;
          state_d = RUN;
        end else begin
          ctl.pc_en       = 1'b0;
          ctl.ifid_en     = !dc;
          ctl.ifid_flush  = 1'b1;
          ctl.idex_bubble = 1'b1;
          ctl.back_en     = !dc;
          if (!dc) begin
            drain_d = drain_q - 2'd1;
            if (drain_q == 2'd1) state_d = HALTED;
          end
        end
      end
      HALTED:  ctl = CTL_FREEZE;
      default: state_d = RUN;
    endcase
    if (!rst) ctl = CTL_RESET;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_q     <= 2'd0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == HALTED);
      if (!ctl.pc_en && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.pc_en       = ctl.pc_en;
  assign bus.ifid_en     = ctl.ifid_en;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_bubble = ctl.idex_bubble;
  assign bus.back_en     = ctl.back_en;
  assign bus.halted      = halted_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, a behavioural model checked
// every cycle, and hand-computed literal expectations.
module tb_pipe_hazard_ctrl;
  localparam int W    = 4;
  localparam int SMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_hazard_ctrl_if #(.STALL_CNT_W(W)) bus();
  pipe_hazard_ctrl #(.STALL_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl_now();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.back_en};
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 draining after HLT, 2 halted
  int         m_mode = 0, m_rem = 0, m_stall = 0;
  int         n_mode, n_rem, n_stall;
  logic [4:0] m_exp;

  function automatic logic load_use(input logic [15:0] ins, input logic memrd, input logic [3:0] rd);
    logic [3:0] srcs[$];
    int op;
    op = int'(ins[15:12]);
    if (op <= 9 || op == 13) srcs.push_back(ins[7:4]);
    if (op <= 3 || op == 7)  srcs.push_back(ins[3:0]);
    if (op == 9)             srcs.push_back(ins[11:8]);
    if (!memrd || rd == 4'd0) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == rd) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    n_mode = m_mode; n_rem = m_rem;
    if (!rst) m_exp = 5'b01110;
    else if (m_mode == 2) m_exp = 5'b00000;
    else if (m_mode == 1) begin
      if (bus.branch_taken && !bus.dcache_stall) begin
        m_exp = 5'b11111; n_mode = 0;
      end else begin
        m_exp = {1'b0, !bus.dcache_stall, 2'b11, !bus.dcache_stall};
        if (!bus.dcache_stall) begin
          n_rem = m_rem - 1;
          if (n_rem == 0) n_mode = 2;
        end
      end
    end else begin
      if (bus.dcache_stall) m_exp = 5'b00000;
      else if (bus.branch_taken) m_exp = 5'b11111;
      else if (load_use(bus.ifid_instr, bus.idex_memrd, bus.idex_rd)) m_exp = 5'b00011;
      else if (bus.icache_stall) m_exp = 5'b01101;
      else if (bus.ifid_instr[15:12] == 4'hF) begin
        m_exp = 5'b01101; n_mode = 1; n_rem = 3;
      end else m_exp = 5'b11001;
    end
    chk("model_ctl", 32'(ctl_now()), 32'(m_exp));
    chk("model_halted", 32'(bus.halted), 32'(m_mode == 2));
    chk("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    n_stall = (!m_exp[4] && m_stall < SMAX) ? m_stall + 1 : m_stall;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_rem = 0; m_stall = 0;
    end else begin
      m_mode = n_mode; m_rem = n_rem; m_stall = n_stall;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [15:0] ins, input logic memrd, input logic [3:0] rd,
                       input logic br, input logic ic, input logic dc);
    bus.ifid_instr   = ins;
    bus.idex_memrd   = memrd;
    bus.idex_rd      = rd;
    bus.branch_taken = br;
    bus.icache_stall = ic;
    bus.dcache_stall = dc;
  endtask

  // Apply a vector just after the rising edge and check mid-cycle.
  task automatic vec(input string name, input logic [15:0] ins, input logic memrd,
                     input logic [3:0] rd, input logic br, input logic ic,
                     input logic dc, input logic [4:0] exp_ctl);
    @(posedge clk); #1;
    drive(ins, memrd, rd, br, ic, dc);
    @(negedge clk);
    chk(name, 32'(ctl_now()), 32'(exp_ctl));
  endtask

  initial begin
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl_now()), 32'(5'b01110));
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_stall", 32'(bus.stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("first_fetch", 32'(ctl_now()), 32'(5'b11001));
    chk("first_stall", 32'(bus.stall_cnt), 32'd0);

    vec("lu_add",      16'h0132, 1, 4'd3, 0, 0, 0, 5'b00011);
    vec("lu_after",    16'h0132, 0, 4'd3, 0, 0, 0, 5'b11001);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    vec("lu_rd0",      16'h0132, 1, 4'd0, 0, 0, 0, 5'b11001);
    vec("lu_store",    16'h9300, 1, 4'd3, 0, 0, 0, 5'b00011);
    vec("no_src_op",   16'hA033, 1, 4'd3, 0, 0, 0, 5'b11001);
    vec("branch",      16'h0000, 0, 4'd0, 1, 0, 0, 5'b11111);
    vec("after_br",    16'h0000, 0, 4'd0, 0, 0, 0, 5'b11001);
    for (int i = 0; i < 5; i++)
      vec("freeze_br", 16'h0000, 0, 4'd0, 1, 0, 1, 5'b00000);
    vec("br_after_frz", 16'h0000, 0, 4'd0, 1, 0, 0, 5'b11111);
    chk("freeze_stall_cnt", 32'(bus.stall_cnt), 32'd7);
    vec("idle",        16'h0000, 0, 4'd0, 0, 0, 0, 5'b11001);
    vec("icache",      16'h0000, 0, 4'd0, 0, 1, 0, 5'b01101);
    vec("hlt_id",      16'hF000, 0, 4'd0, 0, 0, 0, 5'b01101);
    vec("drain1",      16'h0000, 0, 4'd0, 0, 0, 0, 5'b01111);
    vec("drain_dc1",   16'h0000, 0, 4'd0, 0, 0, 1, 5'b00110);
    vec("drain_dc2",   16'h0000, 0, 4'd0, 0, 0, 1, 5'b00110);
    vec("drain2",      16'h0000, 0, 4'd0, 0, 0, 0, 5'b01111);
    chk("drain_not_halted", 32'(bus.halted), 32'd0);
    vec("drain3",      16'h0000, 0, 4'd0, 0, 0, 0, 5'b01111);
    vec("halted_ctl",  16'h0000, 0, 4'd0, 0, 0, 0, 5'b00000);
    chk("halted_set", 32'(bus.halted), 32'd1);
    chk("halted_stall_cnt", 32'(bus.stall_cnt), 32'd14);
    vec("halted_br",   16'h0000, 0, 4'd0, 1, 0, 0, 5'b00000);
    vec("halted_hold", 16'h0000, 0, 4'd0, 0, 0, 0, 5'b00000);
    chk("stall_saturate", 32'(bus.stall_cnt), 32'(SMAX));
    chk("halted_stays", 32'(bus.halted), 32'd1);

    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("async_rst_halted", 32'(bus.halted), 32'd0);
    chk("async_rst_ctl", 32'(ctl_now()), 32'(5'b01110));
    chk("async_rst_stall", 32'(bus.stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rerun", 32'(ctl_now()), 32'(5'b11001));

    vec("hlt_spec",    16'hF000, 0, 4'd0, 0, 0, 0, 5'b01101);
    vec("drain_br",    16'h0000, 0, 4'd0, 1, 0, 0, 5'b11111);
    vec("back_to_run", 16'h0000, 0, 4'd0, 0, 0, 0, 5'b11001);
    chk("spec_hlt_stall", 32'(bus.stall_cnt), 32'd1);
    vec("lu_br_rs",    16'hD030, 1, 4'd3, 0, 0, 0, 5'b00011);
    vec("lu_rt_op7",   16'h7003, 1, 4'd3, 0, 0, 0, 5'b00011);
    vec("no_rt_op4",   16'h4003, 1, 4'd3, 0, 0, 0, 5'b11001);
    vec("final_idle",  16'h0000, 0, 4'd0, 0, 0, 0, 5'b11001);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
